// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared LFSR state encoding and next-state rule for generator and checker
package lfsr_pkg;

    localparam int LFSR_MAX_W = 32;

    typedef logic [LFSR_MAX_W-1:0] lfsr_word_t;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        LOCKING = 2'd1,
        LOCKED  = 2'd2
    } lfsr_state_e;

    // Values are carried zero-extended to LFSR_MAX_W; bits at and above width are forced to 0.
    function automatic lfsr_word_t lfsr_next(input lfsr_word_t s, input lfsr_word_t taps,
                                             input int width);
        lfsr_word_t r;
        r = {s[LFSR_MAX_W-2:0], ^(s & taps)};
        for (int i = 0; i < LFSR_MAX_W; i++) begin
            if (i >= width) r[i] = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - self-synchronising LFSR sequence checker with lock, error and lock-up status
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int ERR_W    = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] taps,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    input  logic             clear_errors,
    output logic             locked,
    output logic             error_pulse,
    output logic [ERR_W-1:0] error_count,
    output logic             zero_seen
);

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W  = $clog2(LOSS_CNT + 1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    lfsr_state_e        state, state_n;
    logic [MATCH_W-1:0] match_cnt, match_n, match_inc;
    logic [MISS_W-1:0]  miss_cnt, miss_n, miss_inc;
    logic               have_prev, have_prev_n;
    logic [WIDTH-1:0]   prev, prev_n;
    lfsr_word_t         pred, pred_n;
    logic               locked_n, pulse_n, zero_n, err_hit;
    logic [ERR_W-1:0]   cnt_base, cnt_n;

    lfsr_word_t taps_w, data_w, nxt_prev, nxt_data, nxt_pred;

    always_comb begin
        taps_w   = LFSR_MAX_W'(taps);
        data_w   = LFSR_MAX_W'(data_in);
        nxt_prev = lfsr_next(LFSR_MAX_W'(prev), taps_w, WIDTH);
        nxt_data = lfsr_next(data_w, taps_w, WIDTH);
        nxt_pred = lfsr_next(pred, taps_w, WIDTH);
    end

    always_comb begin
        state_n     = state;
        match_n     = match_cnt;
        miss_n      = miss_cnt;
        have_prev_n = have_prev;
        prev_n      = prev;
        pred_n      = pred;
        locked_n    = locked;
        pulse_n     = 1'b0;
        err_hit     = 1'b0;
        zero_n      = zero_seen | (data_valid && (data_in == '0));
        match_inc   = match_cnt + MATCH_W'(1);
        miss_inc    = miss_cnt + MISS_W'(1);

        if (data_valid) begin
            case (state)
                HUNT, LOCKING: begin
                    prev_n      = data_in;
                    have_prev_n = 1'b1;
                    // First sample after reset or loss only seeds prev.
                    if (have_prev) begin
                        if ((data_w == nxt_prev) && (data_in != '0)) begin
                            if (match_inc == MATCH_W'(LOCK_CNT)) begin
                                state_n  = LOCKED;
                                locked_n = 1'b1;
                                match_n  = '0;
                                miss_n   = '0;
                                pred_n   = nxt_data;
                            end else begin
                                state_n = LOCKING;
                                match_n = match_inc;
                            end
                        end else begin
                            state_n = HUNT;
                            match_n = '0;
                        end
                    end
                end
                LOCKED: begin
                    // Flywheel: prediction advances regardless of the outcome.
                    pred_n = nxt_pred;
                    if (data_w != pred) begin
                        pulse_n = 1'b1;
                        err_hit = 1'b1;
                        if (miss_inc == MISS_W'(LOSS_CNT)) begin
                            state_n     = HUNT;
                            locked_n    = 1'b0;
                            match_n     = '0;
                            miss_n      = '0;
                            have_prev_n = 1'b0;
                        end else begin
                            miss_n = miss_inc;
                        end
                    end else begin
                        miss_n = '0;
                    end
                end
                default: begin
                    state_n     = HUNT;
                    locked_n    = 1'b0;
                    match_n     = '0;
                    miss_n      = '0;
                    have_prev_n = 1'b0;
                end
            endcase
        end

        cnt_base = clear_errors ? '0 : error_count;
        if (err_hit && (cnt_base != ERR_MAX)) cnt_n = cnt_base + ERR_W'(1);
        else                                  cnt_n = cnt_base;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= HUNT;
            match_cnt   <= '0;
            miss_cnt    <= '0;
            have_prev   <= 1'b0;
            prev        <= '0;
            pred        <= '0;
            locked      <= 1'b0;
            error_pulse <= 1'b0;
            error_count <= '0;
            zero_seen   <= 1'b0;
        end else begin
            state       <= state_n;
            match_cnt   <= match_n;
            miss_cnt    <= miss_n;
            have_prev   <= have_prev_n;
            prev        <= prev_n;
            pred        <= pred_n;
            locked      <= locked_n;
            error_pulse <= pulse_n;
            error_count <= cnt_n;
            zero_seen   <= zero_n;
        end
    end

endmodule
